// File: rtl/lebug_pkg.sv
// ---------------------------------------------------------------------------
// lebug_pkg -- shared definitions for the trace packer.
//   pack_state_e : packer FSM state (FILL assembling, SEND vector held)
//   lane_idx_w() : width of a lane index for an N-lane vector (minimum 1)
// ---------------------------------------------------------------------------
package lebug_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SEND = 1'b1
  } pack_state_e;

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trace_packer_stats.sv
// ---------------------------------------------------------------------------
// trace_packer_stats -- enqueue statistics for the trace packer.
// Only instantiated when TRACE_PACKER_STATS_EN is defined.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_enqueue       : vector written to the input buffer this cycle
//   i_eof           : that vector closes a frame
//   o_frame_count   : enqueues with end of frame (wraps at 2^16)
//   o_vector_count  : all enqueues (wraps at 2^16)
// ---------------------------------------------------------------------------
module trace_packer_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enqueue,
  input  logic        i_eof,
  output logic [15:0] o_frame_count,
  output logic [15:0] o_vector_count
);

  logic [15:0] r_frame_count;
  logic [15:0] r_vector_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count  <= '0;
      r_vector_count <= '0;
    end else if (i_enqueue) begin
      r_vector_count <= r_vector_count + 16'd1;
      if (i_eof) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_frame_count  = r_frame_count;
  assign o_vector_count = r_vector_count;

endmodule

// File: rtl/trace_packer.sv
// ---------------------------------------------------------------------------
// trace_packer -- packs a stream of trace elements into N-lane vectors and
// writes each completed vector to a downstream input buffer.
//
// Handshakes (strict valid/ready):
//   upstream  : an element transfers on a rising edge where
//               elem_valid & elem_ready; otherwise upstream holds it.
//   downstream: enqueue is a one-cycle write strobe; it is only raised when
//               ib_full is low, so every strobe is a completed transfer.
//               eof_out and vector_out are meaningful only with enqueue.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   tracing              : trace enable; falling edge flushes a partial vector
//   elem_valid/data/last : upstream element, last marks end of frame
//   elem_ready           : element accepted this cycle
//   ib_full              : downstream cannot take a vector this cycle
//   enqueue              : vector write strobe
//   eof_out, vector_out  : vector contents (lane 0 = vector_out[0])
//   o_dbg_state          : current FSM state
//   frame_count, vector_count : only with TRACE_PACKER_STATS_EN defined
// ---------------------------------------------------------------------------
module trace_packer
  import lebug_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tracing,
  input  logic                             elem_valid,
  input  logic [DATA_WIDTH-1:0]            elem_data,
  input  logic                             elem_last,
  output logic                             elem_ready,
  input  logic                             ib_full,
  output logic                             enqueue,
  output logic                             eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
`ifdef TRACE_PACKER_STATS_EN
  output logic [15:0]                      frame_count,
  output logic [15:0]                      vector_count,
`endif
  output pack_state_e                      o_dbg_state
);

  localparam int             LW        = lane_idx_w(N);
  localparam logic [LW-1:0]  LAST_LANE = LW'(N - 1);

  pack_state_e                      r_state;
  logic [LW-1:0]                    r_lane;
  logic [N-1:0][DATA_WIDTH-1:0]     r_lanes;
  logic                             r_eof;

  logic                             w_enq;
  logic                             w_ready;
  logic                             w_accept;
  logic                             w_flush;
  logic                             w_complete;
  logic [N-1:0][DATA_WIDTH-1:0]     w_lanes_nxt;

  assign w_enq      = (r_state == SEND) & !ib_full;
  // Gated by rst_n so no element is taken while reset is asserted.
  assign w_ready    = rst_n & tracing & ((r_state == FILL) | w_enq);
  assign w_accept   = elem_valid & w_ready;
  // Tracing low with a partial vector closes that vector as a frame end.
  assign w_flush    = !tracing & (r_state == FILL) & (r_lane != '0);
  assign w_complete = (w_accept & (elem_last | (r_lane == LAST_LANE))) | w_flush;

  // One lane buffer serves both assembly and output: it is cleared when the
  // held vector leaves, so unwritten lanes are always zero. In SEND the lane
  // counter is 0, so an element accepted during the enqueue lands in lane 0
  // of the freshly cleared buffer.
  always_comb begin
    w_lanes_nxt = r_lanes;
    if (w_enq)    w_lanes_nxt = '0;
    if (w_accept) w_lanes_nxt[r_lane] = elem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_lane  <= '0;
      r_lanes <= '0;
      r_eof   <= 1'b0;
    end else begin
      r_lanes <= w_lanes_nxt;
      if (w_complete) begin
        r_state <= SEND;
        r_lane  <= '0;
        r_eof   <= (w_accept & elem_last) | w_flush;
      end else begin
        if (w_accept) r_lane <= r_lane + LW'(1);
        if (w_enq) begin
          r_state <= FILL;
          r_eof   <= 1'b0;
        end
      end
    end
  end

  assign elem_ready  = w_ready;
  assign enqueue     = w_enq;
  assign eof_out     = r_eof;
  assign vector_out  = r_lanes;
  assign o_dbg_state = r_state;

`ifdef TRACE_PACKER_STATS_EN
  trace_packer_stats u_stats (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enqueue      (w_enq),
    .i_eof          (r_eof),
    .o_frame_count  (frame_count),
    .o_vector_count (vector_count)
  );
`endif

endmodule

// File: tb/tb_trace_packer.sv
// ---------------------------------------------------------------------------
// tb_trace_packer -- directed and random stimulus for trace_packer (N=8,
// DATA_WIDTH=32). Expected vectors come from a small lane model and are
// queued when elements are accepted; a monitor pops them on each enqueue.
// Define TRACE_PACKER_STATS_EN to also exercise the statistic counters.
// ---------------------------------------------------------------------------
module tb_trace_packer;
  import lebug_pkg::*;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int W  = 1 + N * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                  tracing = 1'b0;
  logic                  elem_valid = 1'b0;
  logic [DW-1:0]         elem_data = '0;
  logic                  elem_last = 1'b0;
  logic                  elem_ready;
  logic                  ib_full = 1'b0;
  logic                  enqueue;
  logic                  eof_out;
  logic [N-1:0][DW-1:0]  vector_out;
  pack_state_e           dbg_state;
`ifdef TRACE_PACKER_STATS_EN
  logic [15:0]           frame_count;
  logic [15:0]           vector_count;
`endif

  trace_packer #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tracing      (tracing),
    .elem_valid   (elem_valid),
    .elem_data    (elem_data),
    .elem_last    (elem_last),
    .elem_ready   (elem_ready),
    .ib_full      (ib_full),
    .enqueue      (enqueue),
    .eof_out      (eof_out),
    .vector_out   (vector_out),
`ifdef TRACE_PACKER_STATS_EN
    .frame_count  (frame_count),
    .vector_count (vector_count),
`endif
    .o_dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lane model: mirrors what a packer must emit for accepted elements.
  logic [N-1:0][DW-1:0] m_vec = '0;
  int                   m_lane = 0;

  task automatic model_accept(input logic [DW-1:0] d, input logic last);
    m_vec[m_lane] = d;
    m_lane++;
    if (last || m_lane == N) begin
      exp_q.push_back({last, m_vec});
      m_vec  = '0;
      m_lane = 0;
    end
  endtask

  task automatic model_clear();
    m_vec  = '0;
    m_lane = 0;
  endtask

  // Monitor: samples well inside the low phase, after the bench has driven.
  int enq_cnt = 0;
  int last_enq_cyc = 0;
  int prev_enq_cyc = 0;
  always @(negedge clk) begin
    #4;
    if (enqueue) begin
      enq_cnt++;
      prev_enq_cyc = last_enq_cyc;
      last_enq_cyc = cyc;
      check("enq_expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) check("enq_vector", {eof_out, vector_out}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present one element and hold it until accepted; returns at the step
  // point after the accepting edge with elem_valid low.
  task automatic send(input logic [DW-1:0] d, input logic last, input logic need_ready);
    elem_valid = 1'b1;
    elem_data  = d;
    elem_last  = last;
    #1;
    if (need_ready) check("ready_b2b", W'(elem_ready), W'(1));
    for (int i = 0; i < 40 && !elem_ready; i++) begin
      @(negedge clk);
      #2;
    end
    if (!elem_ready) begin
      check("send_timeout", W'(elem_ready), W'(1));
      elem_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d, last);
    tick();
    elem_valid = 1'b0;
    elem_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    check("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0][DW-1:0] snap;
  int                   enq_before;
  int                   len;

  initial begin
    // Reset state, with an element offered to show it is not taken.
    tracing    = 1'b1;
    elem_valid = 1'b1;
    elem_data  = 32'hDEAD;
    tick();
    tick();
    check("rst_enqueue", W'(enqueue), W'(0));
    check("rst_ready", W'(elem_ready), W'(0));
    check("rst_eof", W'(eof_out), W'(0));
    check("rst_vector", W'(vector_out), W'(0));
    check("rst_state", W'(dbg_state), W'(FILL));
`ifdef TRACE_PACKER_STATS_EN
    check("rst_frames", W'(frame_count), W'(0));
    check("rst_vectors", W'(vector_count), W'(0));
`endif
    elem_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Full frame 1..8, last on lane 7: one enqueue one cycle later.
    for (int i = 1; i <= 8; i++) send(DW'(i), i == 8, 1'b1);
    check("full_lat_enq", W'(enqueue), W'(1));
    tick();
    check("full_no_extra", W'(enqueue), W'(0));
    drain();

    // Short frame 10,11,12.
    enq_before = enq_cnt;
    send(32'd10, 1'b0, 1'b1);
    send(32'd11, 1'b0, 1'b1);
    send(32'd12, 1'b1, 1'b1);
    tick();
    drain();
    check("short_enq_count", W'(enq_cnt - enq_before), W'(1));

    // 16 back-to-back elements: two enqueues 8 cycles apart.
    enq_before = enq_cnt;
    for (int i = 1; i <= 16; i++) send(DW'(32'h100 + i), i == 16, 1'b1);
    tick();
    drain();
    check("b2b_enq_count", W'(enq_cnt - enq_before), W'(2));
    check("b2b_gap", W'(last_enq_cyc - prev_enq_cyc), W'(8));

    // Backpressure at completion for 5 cycles.
    ib_full = 1'b1;
    send(32'h20, 1'b0, 1'b1);
    send(32'h21, 1'b0, 1'b1);
    send(32'h22, 1'b1, 1'b1);
    snap = vector_out;
    for (int i = 0; i < 5; i++) begin
      check("bp_enqueue", W'(enqueue), W'(0));
      check("bp_ready", W'(elem_ready), W'(0));
      check("bp_stable", W'(vector_out), W'(snap));
      check("bp_eof", W'(eof_out), W'(1));
      tick();
    end
    ib_full = 1'b0;
    #1;
    check("bp_release_enq", W'(enqueue), W'(1));
    tick();
    check("bp_single_enq", W'(enqueue), W'(0));
    drain();

    // Tracing falls after 5 elements: partial vector flushed with eof.
    for (int i = 0; i < 5; i++) send(DW'(32'h30 + i), 1'b0, 1'b1);
    tracing = 1'b0;
    exp_q.push_back({1'b1, m_vec});
    model_clear();
    elem_valid = 1'b1;
    elem_data  = 32'h99;
    #1;
    check("flush_ready_lo", W'(elem_ready), W'(0));
    tick();
    check("flush_enq", W'(enqueue), W'(1));
    check("flush_ready_lo2", W'(elem_ready), W'(0));
    tick();
    check("flush_single", W'(enqueue), W'(0));
    check("flush_hold", W'(elem_ready), W'(0));
    elem_valid = 1'b0;
    tracing    = 1'b1;
    drain();

    // Reset mid-fill discards the partial vector.
    enq_before = enq_cnt;
    for (int i = 0; i < 4; i++) send(DW'(32'h40 + i), 1'b0, 1'b1);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("midrst_vector", W'(vector_out), W'(0));
    check("midrst_ready", W'(elem_ready), W'(0));
`ifdef TRACE_PACKER_STATS_EN
    check("midrst_frames", W'(frame_count), W'(0));
    check("midrst_vectors", W'(vector_count), W'(0));
`endif
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_no_enq", W'(enq_cnt - enq_before), W'(0));
    send(32'h41, 1'b0, 1'b1);
    send(32'h42, 1'b0, 1'b1);
    send(32'h43, 1'b1, 1'b1);
    tick();
    drain();
`ifdef TRACE_PACKER_STATS_EN
    check("stats_frames", W'(frame_count), W'(1));
    check("stats_vectors", W'(vector_count), W'(1));
`endif

    // Random frames of 1..12 elements.
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) send(DW'($urandom), i == len - 1, 1'b0);
    end
    tick();
    drain();

    check("final_queue", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_packer.md
TRACE_PACKER -- requirements
Module: trace_packer

Interface
REQ-001 Parameter N, default 8, number of lanes per output vector.
REQ-002 Parameter DATA_WIDTH, default 32, bits per element.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 tracing  input  1  trace enable; element intake only while high.
REQ-006 elem_valid  input  1  upstream element present.
REQ-007 elem_data  input  DATA_WIDTH  element value.
REQ-008 elem_last  input  1  element is final of its frame.
REQ-009 elem_ready  output  1  element accepted when elem_valid & elem_ready.
REQ-010 ib_full  input  1  downstream input buffer cannot take a vector this cycle.
REQ-011 enqueue  output  1  one-cycle write strobe to input buffer.
REQ-012 eof_out  output  1  vector carries end of frame; qualified by enqueue.
REQ-013 vector_out  output  [DATA_WIDTH-1:0] x [N-1:0]  packed vector; qualified by enqueue.

Function
REQ-014 Two states: FILL (assembling) and SEND (completed vector held for output).
REQ-015 Accepted elements fill lanes in order 0..N-1; lane counter width $clog2(N), increments per accepted element.
REQ-016 Vector completes when lane N-1 is written or an element with elem_last=1 is accepted; transition FILL->SEND at that edge, lane counter returns to 0.
REQ-017 Unfilled lanes of a completed vector SHALL be zero.
REQ-018 eof_out SHALL be 1 for a vector completed by elem_last or by tracing flush, else 0.
REQ-019 enqueue SHALL equal (state==SEND) & !ib_full; latency 1 cycle from accepting the completing element to earliest enqueue.
REQ-020 In SEND with ib_full=1: enqueue=0, vector_out/eof_out held stable, state remains SEND.
REQ-021 SEND->FILL on any cycle enqueue=1, unless a new vector completes the same cycle (then remain SEND with new contents).
REQ-022 elem_ready SHALL equal tracing & (state==FILL | (state==SEND & !ib_full)); back-to-back frames sustain one element per cycle.
REQ-023 tracing falling with lane counter nonzero in FILL: next edge SHALL complete the partial vector with eof_out=1 (flush); lane counter 0 -> no vector.
REQ-024 Elements presented while elem_ready=0 are not consumed; upstream holds them.
REQ-025 elem_last on lane N-1 produces exactly one vector with eof_out=1, no extra empty vector.

Reset
REQ-026 rst_n low: state=FILL, lane counter=0, all lanes 0, enqueue=0, eof_out=0, vector_out=0, elem_ready=0 (low for the cycle rst_n is low).
REQ-027 Reset mid-fill or mid-SEND SHALL discard the partial/pending vector with no enqueue.

Configuration
REQ-028 Macro TRACE_PACKER_STATS_EN defined: add outputs frame_count[15:0] (increments on enqueue with eof_out=1) and vector_count[15:0] (increments on each enqueue), both wrap modulo 2^16, both 0 on reset.
REQ-029 Macro undefined: those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-030 Shared package lebug_pkg SHALL hold the packer state enum (FILL, SEND) and the lane-index width helper.
REQ-031 Statistic counters SHALL live in sub-module trace_packer_stats, instantiated only under TRACE_PACKER_STATS_EN; datapath needs no further sub-modules.

Verification (N=8, DATA_WIDTH=32)
REQ-032 Elements 1..8, elem_last on 8, ib_full=0 -> one enqueue one cycle after 8th accept, vector_out={1..8} lane0..7, eof_out=1.
REQ-033 Elements 10,11,12 with last on 12 -> vector_out={10,11,12,0,0,0,0,0}, eof_out=1, single enqueue.
REQ-034 16 consecutive elements, last on 16th, ib_full=0 -> two enqueues 8 cycles apart, eof_out 0 then 1, elem_ready constantly 1.
REQ-035 ib_full=1 for 5 cycles at completion -> enqueue=0, vector stable, elem_ready=0 during those cycles; enqueue=1 for one cycle once ib_full=0.
REQ-036 tracing falls after 5 elements -> one enqueue with lanes 5..7 zero and eof_out=1; no intake until tracing=1.
REQ-037 rst_n pulsed after 4 elements -> no enqueue; next frame begins at lane 0; with TRACE_PACKER_STATS_EN, frame_count and vector_count read 0.
